png_row_buf_ctl: RTL

Initiator-side controller for the register-based single-port row RAM in the PNG filter path. Accepts a raster pixel stream, fetches the co-located pixel of the previous row ("up" sample) from the RAM, overwrites that location with the current pixel, and emits current/up pairs aligned for the scanline filter. One RAM transaction per cycle, so one pixel is accepted every two cycles: a read cycle, then a write cycle.

---
 rtl/png_row_buf_ctl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/png_row_buf_ctl.sv
// Row-buffer controller: fetches the previous-row pixel from a single-port RAM, overwrites it
// with the current pixel and emits current/up pairs. Define ROW_BUF_CHK_EN for the read-valid checker.
module png_row_buf_ctl #(
  parameter int  SIZE    = -1,
  parameter int  DATA_WD = -1,
  localparam int SIZE_WD = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [SIZE_WD:0]   cfg_wid_i,
  input  logic [15:0]        cfg_hgt_i,
  input  logic               pix_val_i,
  output logic               pix_rdy_o,
  input  logic [DATA_WD-1:0] pix_dat_i,
  output logic               out_val_o,
  output logic [DATA_WD-1:0] out_cur_o,
  output logic [DATA_WD-1:0] out_up_o,
  output logic               out_lst_o,
  output logic               done_o,
  output logic [SIZE_WD-1:0] ram_adr_o,
  output logic               ram_wr_val_o,
  output logic [DATA_WD-1:0] ram_wr_dat_o,
  output logic               ram_rd_val_o,
  input  logic               ram_rd_val_i,
  input  logic [DATA_WD-1:0] ram_rd_dat_i,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, ACPT, WR, DONE} state_t;

  localparam logic [SIZE_WD:0] SIZE_C = (SIZE_WD+1)'(SIZE);

  state_t             state;
  logic [SIZE_WD:0]   wid;
  logic [SIZE_WD:0]   col;
  logic [15:0]        hgt;
  logic [15:0]        row;
  logic [DATA_WD-1:0] hold;

  logic               xfer;
  logic               col_lst;
  logic               row_lst;
  logic [SIZE_WD:0]   wid_clamp;

  assign xfer      = (state == ACPT) && pix_val_i;
  assign col_lst   = (col == wid - 1'b1);
  assign row_lst   = (row == hgt - 16'd1);
  assign wid_clamp = (cfg_wid_i > SIZE_C) ? SIZE_C : cfg_wid_i;

  // RAM port: read on the accepting cycle, write on the following one
  always_comb begin
    pix_rdy_o    = (state == ACPT);
    ram_adr_o    = '0;
    ram_rd_val_o = 1'b0;
    ram_wr_val_o = 1'b0;
    ram_wr_dat_o = '0;
    if (xfer) begin
      ram_adr_o    = col[SIZE_WD-1:0];
      ram_rd_val_o = (row != 16'd0);
    end else if (state == WR) begin
      ram_adr_o    = col[SIZE_WD-1:0];
      ram_wr_val_o = 1'b1;
      ram_wr_dat_o = hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wid       <= '0;
      col       <= '0;
      hgt       <= '0;
      row       <= '0;
      hold      <= '0;
      out_val_o <= 1'b0;
      out_cur_o <= '0;
      out_up_o  <= '0;
      out_lst_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      out_val_o <= 1'b0;
      out_lst_o <= 1'b0;
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            wid   <= wid_clamp;
            hgt   <= cfg_hgt_i;
            col   <= '0;
            row   <= '0;
            state <= (wid_clamp == '0 || cfg_hgt_i == 16'd0) ? DONE : ACPT;
          end
        end
        ACPT: begin
          if (pix_val_i) begin
            hold  <= pix_dat_i;
            state <= WR;
          end
        end
        WR: begin
          out_val_o <= 1'b1;
          out_cur_o <= hold;
          out_up_o  <= (row == 16'd0) ? '0 : ram_rd_dat_i;
          out_lst_o <= col_lst;
          if (col_lst) begin
            col <= '0;
            if (row_lst) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              row   <= row + 16'd1;
              state <= ACPT;
            end
          end else begin
            col   <= col + 1'b1;
            state <= ACPT;
          end
        end
        DONE: begin
          // Arrived from WR: done_o already high with the last pair, drop it.
          // Arrived from an empty start: raise it now.
          done_o <= ~done_o;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROW_BUF_CHK_EN
  logic rd_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      rd_pend <= ram_rd_val_o;
      if (rd_pend != ram_rd_val_i) err_o <= 1'b1;
    end
  end
`else
  logic rd_val_unused;

  assign rd_val_unused = ram_rd_val_i;
  assign err_o         = 1'b0;
`endif

endmodule
